// File: rtl/eth_pkg.sv
// Shared types and constants for the MII receive path: FSM encoding, preamble/SFD
// nibbles, CRC-32 parameters and frame length limits.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_HEADER,
      ST_DATA,
      ST_DROP
   } rx_state_t;

   localparam logic [3:0]  PRE_NIB      = 4'h5;
   localparam logic [3:0]  SFD_NIB      = 4'hD;
   localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
   localparam logic [10:0] FRAME_MIN    = 11'd64;
   localparam logic [10:0] FRAME_MAX    = 11'd1518;
   localparam logic [10:0] HDR_LAST     = 11'd13;
   localparam logic [11:0] DATA_LEN_MAX = 12'd1514;

   // Register kept in MSB-first form while data bits enter LSB-first, so a good
   // frame plus its FCS leaves the register equal to CRC_RESIDUE.
   function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_mac_rx_crc32_d8.sv
// Byte-wide CRC-32 accumulator: combinational next value, registered state.
// Instantiated by eth_mac_rx only when RX_CRC_CHECK_EN is defined.
module crc32_d8
   import eth_pkg::*;
(
   input  logic        mii_rx_clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   always_ff @(posedge mii_rx_clk or negedge rst_n) begin
      if (!rst_n)    crc <= '0;
      else if (init) crc <= CRC_INIT;
      else if (en)   crc <= crc32_next(crc, data);
   end

endmodule

// File: rtl/eth_mac_rx.sv
// MII receive MAC: preamble/SFD detect, header capture, FCS-stripping payload stream
// and frame status. Define RX_CRC_CHECK_EN to add CRC-32 checking to frame_ok.
//
// state       | meaning
// ST_IDLE     | waiting for dv with a preamble nibble
// ST_PREAMBLE | counting 0x5 nibbles until SFD
// ST_HEADER   | assembling the 14 header bytes
// ST_DATA     | payload through 4-byte delay line (drops FCS)
// ST_DROP     | discard until dv low (also the post-reset state)
module eth_mac_rx
   import eth_pkg::*;
(
   input  logic        mii_rx_clk,
   input  logic        rst_n,
   input  logic        mii_rx_dv,
   input  logic        mii_rx_er,
   input  logic [3:0]  mii_rx_da,
   output logic [47:0] des_mac,
   output logic [47:0] src_mac,
   output logic [15:0] len_type,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        frame_start,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [11:0] data_len
);

   rx_state_t   state, state_nxt;
   logic        quiet;
   logic        nib_phase;
   logic [3:0]  lo_nib;
   logic [10:0] byte_cnt;
   logic [31:0] dline;
   logic [2:0]  fill;
   logic [7:0]  byte_val;
   logic        in_frame, byte_done, len_ok, crc_ok;
   logic        sfd_hit, pre_start, done_nxt, ok_nxt;

   assign in_frame  = (state == ST_HEADER) || (state == ST_DATA);
   assign byte_val  = {mii_rx_da, lo_nib};
   assign byte_done = in_frame && mii_rx_dv && !mii_rx_er && nib_phase;
   assign len_ok    = (byte_cnt >= FRAME_MIN) && (byte_cnt <= FRAME_MAX);

`ifdef RX_CRC_CHECK_EN
   logic [31:0] crc;

   crc32_d8 u_crc (
      .mii_rx_clk (mii_rx_clk),
      .rst_n      (rst_n),
      .init       (sfd_hit),
      .en         (byte_done),
      .data       (byte_val),
      .crc        (crc)
   );

   assign crc_ok = (crc == CRC_RESIDUE);
`else
   assign crc_ok = 1'b1;
`endif

   // quiet marks the post-reset DROP, which must finish without a frame_done
   always_ff @(posedge mii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_DROP;
         quiet <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == ST_DROP && !mii_rx_dv) quiet <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      sfd_hit   = 1'b0;
      pre_start = 1'b0;
      done_nxt  = 1'b0;
      ok_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mii_rx_dv && mii_rx_da == PRE_NIB) begin
               state_nxt = ST_PREAMBLE;
               pre_start = 1'b1;
            end
         end
         ST_PREAMBLE: begin
            if (!mii_rx_dv) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end else if (mii_rx_er) begin
               state_nxt = ST_DROP;
            end else if (mii_rx_da == SFD_NIB) begin
               state_nxt = ST_HEADER;
               sfd_hit   = 1'b1;
            end else if (mii_rx_da != PRE_NIB) begin
               state_nxt = ST_DROP;
            end
         end
         ST_HEADER: begin
            if (!mii_rx_dv) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end else if (mii_rx_er) begin
               state_nxt = ST_DROP;
            end else if (byte_done && byte_cnt == HDR_LAST) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!mii_rx_dv) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
               ok_nxt    = !mii_rx_er && !nib_phase && len_ok && crc_ok;
            end else if (mii_rx_er) begin
               state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            if (!mii_rx_dv) begin
               state_nxt = ST_IDLE;
               done_nxt  = !quiet;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge mii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         des_mac     <= '0;
         src_mac     <= '0;
         len_type    <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_ok    <= 1'b0;
         data_len    <= '0;
         nib_phase   <= 1'b0;
         lo_nib      <= '0;
         byte_cnt    <= '0;
         dline       <= '0;
         fill        <= '0;
      end else begin
         frame_start <= sfd_hit;
         frame_done  <= done_nxt;
         data_valid  <= 1'b0;
         if (done_nxt)  frame_ok <= ok_nxt;
         if (pre_start) data_len <= '0;
         if (sfd_hit) begin
            nib_phase <= 1'b0;
            byte_cnt  <= '0;
            fill      <= '0;
            data_len  <= '0;
         end else if (in_frame && mii_rx_dv && !mii_rx_er) begin
            nib_phase <= ~nib_phase;
            if (!nib_phase) lo_nib <= mii_rx_da;
            if (byte_done) begin
               // saturate one past the max so oversize frames stay flagged
               if (byte_cnt <= FRAME_MAX) byte_cnt <= byte_cnt + 11'd1;
               if (state == ST_HEADER) begin
                  if (byte_cnt < 11'd6)       des_mac  <= {des_mac[39:0], byte_val};
                  else if (byte_cnt < 11'd12) src_mac  <= {src_mac[39:0], byte_val};
                  else                        len_type <= {len_type[7:0], byte_val};
               end else begin
                  dline <= {dline[23:0], byte_val};
                  if (fill == 3'd4) begin
                     data_out   <= dline[31:24];
                     data_valid <= 1'b1;
                     if (data_len != DATA_LEN_MAX) data_len <= data_len + 12'd1;
                  end else begin
                     fill <= fill + 3'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_mac_rx.sv
// Directed self-checking bench for eth_mac_rx: good/bad CRC, rx_er, bad preamble,
// runt, odd nibble, oversize saturation, preamble loss and mid-frame reset.
module tb_eth_mac_rx;

   logic        mii_rx_clk = 1'b0;
   logic        rst_n      = 1'b0;
   logic        mii_rx_dv  = 1'b0;
   logic        mii_rx_er  = 1'b0;
   logic [3:0]  mii_rx_da  = 4'h0;
   logic [47:0] des_mac, src_mac;
   logic [15:0] len_type;
   logic [7:0]  data_out;
   logic        data_valid, frame_start, frame_done, frame_ok;
   logic [11:0] data_len;

   eth_mac_rx dut (
      .mii_rx_clk  (mii_rx_clk),
      .rst_n       (rst_n),
      .mii_rx_dv   (mii_rx_dv),
      .mii_rx_er   (mii_rx_er),
      .mii_rx_da   (mii_rx_da),
      .des_mac     (des_mac),
      .src_mac     (src_mac),
      .len_type    (len_type),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_ok    (frame_ok),
      .data_len    (data_len)
   );

   always #5 mii_rx_clk = ~mii_rx_clk;

   int          tests = 0;
   int          fails = 0;
   int          dv_cnt = 0, fs_cnt = 0, fd_cnt = 0;
   int          dv0, fs0, fd0;
   logic        last_ok = 1'b0;
   logic [11:0] last_len = '0;
   logic [7:0]  rx_buf [0:4095];
   logic [7:0]  fb [0:2047];
   int          flen;
   logic        exp_flip_ok;

   always @(negedge mii_rx_clk) begin
      if (data_valid) begin
         rx_buf[dv_cnt % 4096] <= data_out;
         dv_cnt <= dv_cnt + 1;
      end
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (frame_done) begin
         fd_cnt   <= fd_cnt + 1;
         last_ok  <= frame_ok;
         last_len <= data_len;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fcs_of(input int n);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c ^= {24'h0, fb[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build(input int total);
      logic [31:0] fcs;
      for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
      fb[6] = 8'h00; fb[7] = 8'h0A; fb[8] = 8'h35; fb[9] = 8'h01; fb[10] = 8'h02; fb[11] = 8'h03;
      fb[12] = 8'h08; fb[13] = 8'h00;
      for (int i = 14; i < total - 4; i++) fb[i] = 8'(i * 7 + 3);
      fcs = fcs_of(total - 4);
      fb[total-4] = fcs[7:0];
      fb[total-3] = fcs[15:8];
      fb[total-2] = fcs[23:16];
      fb[total-1] = fcs[31:24];
      flen = total;
   endtask

   task automatic nib(input logic dv, input logic er, input logic [3:0] da);
      @(negedge mii_rx_clk);
      mii_rx_dv = dv;
      mii_rx_er = er;
      mii_rx_da = da;
   endtask

   task automatic finish_frame();
      repeat (10) nib(1'b0, 1'b0, 4'h0);
      @(posedge mii_rx_clk);
      #1;
   endtask

   task automatic snap();
      dv0 = dv_cnt;
      fs0 = fs_cnt;
      fd0 = fd_cnt;
   endtask

   task automatic send(input int bad_pre, input int er_byte, input bit odd, input int rst_byte);
      for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, (i == bad_pre) ? 4'h7 : 4'h5);
      nib(1'b1, 1'b0, 4'hD);
      for (int b = 0; b < flen; b++) begin
         if (b == rst_byte)     rst_n = 1'b0;
         if (b == rst_byte + 2) rst_n = 1'b1;
         nib(1'b1, (b == er_byte), fb[b][3:0]);
         nib(1'b1, 1'b0, fb[b][7:4]);
      end
      if (odd) nib(1'b1, 1'b0, 4'hA);
      finish_frame();
   endtask

   initial begin
      repeat (3) @(posedge mii_rx_clk);
      #1;
      check("rst_des_mac", des_mac, 0);
      check("rst_src_mac", src_mac, 0);
      check("rst_len_type", len_type, 0);
      check("rst_data_out", data_out, 0);
      check("rst_strobes", {data_valid, frame_start, frame_done, frame_ok}, 0);
      check("rst_data_len", data_len, 0);
      @(negedge mii_rx_clk);
      rst_n = 1'b1;
      repeat (4) @(posedge mii_rx_clk);
      #1;
      check("rst_no_done", fd_cnt, 0);

      // good 64-byte frame
      build(64); snap(); send(-1, -1, 1'b0, -1);
      check("good_valid_cnt", dv_cnt - dv0, 46);
      check("good_start_cnt", fs_cnt - fs0, 1);
      check("good_done_cnt", fd_cnt - fd0, 1);
      check("good_ok", last_ok, 1);
      check("good_len", last_len, 46);
      check("good_des", des_mac, 48'hFFFFFFFFFFFF);
      check("good_src", src_mac, 48'h000A35010203);
      check("good_type", len_type, 16'h0800);
      for (int i = 0; i < 46; i++)
         check($sformatf("good_pay%0d", i), rx_buf[(dv0 + i) % 4096], fb[14 + i]);

      // one payload bit flipped after the FCS was computed
`ifdef RX_CRC_CHECK_EN
      exp_flip_ok = 1'b0;
`else
      exp_flip_ok = 1'b1;
`endif
      build(64); fb[19] = fb[19] ^ 8'h10; snap(); send(-1, -1, 1'b0, -1);
      check("flip_valid_cnt", dv_cnt - dv0, 46);
      check("flip_ok", last_ok, exp_flip_ok);

      // rx_er at payload byte 10 (frame byte 24)
      build(64); snap(); send(-1, 24, 1'b0, -1);
      check("er_valid_cnt", dv_cnt - dv0, 6);
      check("er_done_cnt", fd_cnt - fd0, 1);
      check("er_ok", last_ok, 0);
      check("er_len", last_len, 6);

      // bad preamble nibble
      build(64); snap(); send(3, -1, 1'b0, -1);
      check("pre7_start_cnt", fs_cnt - fs0, 0);
      check("pre7_done_cnt", fd_cnt - fd0, 1);
      check("pre7_ok", last_ok, 0);
      check("pre7_len", last_len, 0);
      check("pre7_valid_cnt", dv_cnt - dv0, 0);

      // 40-byte runt with correct FCS
      build(40); snap(); send(-1, -1, 1'b0, -1);
      check("runt_valid_cnt", dv_cnt - dv0, 22);
      check("runt_ok", last_ok, 0);
      check("runt_len", last_len, 22);

      // good frame with a trailing odd nibble
      build(64); snap(); send(-1, -1, 1'b1, -1);
      check("odd_done_cnt", fd_cnt - fd0, 1);
      check("odd_ok", last_ok, 0);
      check("odd_len", last_len, 46);

      // preamble loss
      snap();
      repeat (3) nib(1'b1, 1'b0, 4'h5);
      finish_frame();
      check("ploss_done_cnt", fd_cnt - fd0, 1);
      check("ploss_start_cnt", fs_cnt - fs0, 0);
      check("ploss_ok", last_ok, 0);
      check("ploss_len", last_len, 0);

      // oversize frame: payload count saturates
      build(1540); snap(); send(-1, -1, 1'b0, -1);
      check("big_valid_cnt", dv_cnt - dv0, 1522);
      check("big_len", last_len, 1514);
      check("big_ok", last_ok, 0);

      // reset mid-payload, released while dv is still high
      build(64); snap(); send(-1, -1, 1'b0, 34);
      check("mrst_done_cnt", fd_cnt - fd0, 0);
      check("mrst_len", data_len, 0);
      check("mrst_ok", frame_ok, 0);
      check("mrst_des", des_mac, 0);
      build(64); snap(); send(-1, -1, 1'b0, -1);
      check("post_done_cnt", fd_cnt - fd0, 1);
      check("post_ok", last_ok, 1);
      check("post_len", last_len, 46);
      check("post_valid_cnt", dv_cnt - dv0, 46);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
